// File: rtl/lcd_fifo_ctrl.sv
// Bus-slave command FIFO feeding an HD44780-style LCD write sequencer.
// Each queued byte is sent as one 8-bit phase or two 4-bit phases, followed by an execution wait.
module lcd_fifo_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int BUS_4BIT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int M1 = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int M2 = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int M3 = (M2 > T_EXEC) ? M2 : T_EXEC;
    localparam int M4 = (M3 > T_EXEC_LONG) ? M3 : T_EXEC_LONG;
    localparam int CW = $clog2(M4 + 1);

    localparam logic [CW-1:0] C_SETUP     = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_EN        = CW'(T_EN - 1);
    localparam logic [CW-1:0] C_HOLD      = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_EXEC      = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] C_EXEC_LONG = CW'(T_EXEC_LONG - 1);
    localparam logic [AW:0]   FULL_LEVEL  = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic [5:0]    level6;
    logic [8:0]    head;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          busy;
    logic          long_exec;
    logic          low_phase;
    logic          cur_rs;
    logic [7:0]    cur;
    logic [7:0]    lcd_data_q;

    assign level     = wr_ptr - rd_ptr;
    assign level6    = 6'(level);
    assign empty     = (level == '0);
    assign full      = (level == FULL_LEVEL);
    assign push_req  = chipselect && write && !address[1];
    // Fullness is judged on the registered level only, so a same-cycle pop never frees a slot.
    assign waitrequest = push_req && full;
    assign push      = push_req && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;
    assign long_exec = !cur_rs && (cur <= 8'h03);

    assign LCD_DATA  = lcd_data_q;
    assign LCD_RW    = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {address[0], writedata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LCD_ON   <= 1'b0;
            LCD_BLON <= 1'b0;
        end else if (chipselect && write && address == 2'd3) begin
            LCD_ON   <= writedata[0];
            LCD_BLON <= writedata[1];
        end
    end

    // In 4-bit mode HOLD loops back to SETUP once to send the low nibble before EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur        <= 8'h00;
            cur_rs     <= 1'b0;
            low_phase  <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_RS     <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur        <= head[7:0];
                        cur_rs     <= head[8];
                        LCD_RS     <= head[8];
                        lcd_data_q <= (BUS_4BIT != 0) ? {head[7:4], 4'h0} : head[7:0];
                        low_phase  <= 1'b0;
                        cnt        <= C_SETUP;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        LCD_EN <= 1'b1;
                        cnt    <= C_EN;
                        state  <= ENABLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ENABLE: begin
                    if (cnt == '0) begin
                        LCD_EN <= 1'b0;
                        cnt    <= C_HOLD;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if ((BUS_4BIT != 0) && !low_phase) begin
                            low_phase  <= 1'b1;
                            lcd_data_q <= {cur[3:0], 4'h0};
                            cnt        <= C_SETUP;
                            state      <= SETUP;
                        end else begin
                            cnt   <= long_exec ? C_EXEC_LONG : C_EXEC;
                            state <= EXEC;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EXEC: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = 8'h00;
        if (chipselect && read) begin
            case (address)
                2'd2:    readdata = {level6, full, busy};
                2'd3:    readdata = {6'b0, LCD_BLON, LCD_ON};
                default: readdata = 8'h00;
            endcase
        end
    end

endmodule
